serial_adder_sub: RTL and testbench
===================================

Name: serial_adder_sub

Overview:
- Multi-cycle, parametrised two's-complement adder/subtractor. Processes CHUNK bits per clock through a chained ripple stage and a registered inter-chunk carry.
- Generalises the single-bit full adder to WIDTH-bit operands, adds a subtract mode and signed overflow, and wraps it in valid/ready handshakes.
- Sits between an operand-issuing controller and a result consumer, where area matters more than latency.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH
NCHUNK (localparam), WIDTH/CHUNK, processing cycles per operation

Ports:
clock  in  1  single clock; all state updates on posedge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  operands and mode presented
in_ready  out  1  block can accept; high only in IDLE
operand_a  in  WIDTH  first operand
operand_b  in  WIDTH  second operand
sub  in  1  0 = a+b, 1 = a-b
out_valid  out  1  result registers hold a completed result
out_ready  in  1  consumer takes result
sum  out  WIDTH  result, modulo 2^WIDTH
c_out  out  1  carry out of MSB (for sub: 1 = no borrow)
overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, sum=0, c_out=0, overflow=0, out_valid=0, chunk counter=0, carry reg=0. in_ready=1 once in IDLE.
- in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- IDLE: on in_valid&&in_ready at a posedge:
  - latch operand_a;
  - latch operand_b XOR {WIDTH{sub}};
  - carry reg <= sub;
  - counter <= 0;
  - go to ADD.
  - in_valid while not in IDLE is ignored; there is no queueing.
- ADD, one chunk per posedge, LSB chunk first:
  - the CHUNK-bit slice of A, B and the carry reg feeds a CHUNK-bit ripple adder;
  - the result slice shifts into sum from the top (sum >> CHUNK);
  - the A/B shift registers shift right by CHUNK;
  - carry reg <= chunk carry out;
  - counter increments.
- Last chunk (counter==NCHUNK-1):
  - c_out <= chunk carry out;
  - overflow <= carry into bit CHUNK-1 of the chunk XOR chunk carry out;
  - go to DONE.
- Latency: out_valid rises exactly NCHUNK posedges after the accepting posedge.
- DONE: sum, c_out and overflow are held stable while out_ready=0 (arbitrary stall). On out_ready=1 at a posedge, go to IDLE; in_ready is high the following cycle.
- No same-cycle result-drain-and-accept: minimum issue interval is NCHUNK+2 cycles.
- sum, c_out and overflow hold their last values in IDLE. They are don't-care (visible internal shifting) during ADD.
- Reset asserted mid-ADD or mid-DONE aborts the operation immediately; the result is discarded and all outputs take their reset values.
- Boundaries:
  - counter must wrap exactly at NCHUNK-1;
  - CHUNK=WIDTH gives single-cycle ADD (NCHUNK=1);
  - CHUNK=1 is pure bit-serial.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit), registered together with c_out/overflow on the last chunk. zero is 1 iff the final sum==0. It resets to 0 and is held through DONE and IDLE like the other flags. It is computed incrementally as an AND of per-chunk zero checks, with no WIDTH-wide reduction on the last cycle.
- Undefined: no zero port, no zero-tracking register; all other behaviour is identical.

Test Plan:
- Build WIDTH=8, CHUNK=4; issue 0x7F + 0x01 -> after 2 cycles out_valid=1, sum=0x80, c_out=0, overflow=1.
- Build WIDTH=8, CHUNK=4; issue 0xFF + 0x01 -> sum=0x00, c_out=1, overflow=0; then sub 0x05 - 0x07 -> sum=0xFE, c_out=0, overflow=0; then sub 0x80 - 0x01 -> sum=0x7F, c_out=1, overflow=1.
- Backpressure: complete an op with out_ready=0 for 5 cycles -> sum/flags unchanged, out_valid=1, in_ready=0, in_valid pulses ignored. Then out_ready=1 for one cycle -> next cycle in_ready=1, out_valid=0.
- Reset mid-op: pull reset_n low one cycle after accepting 0x12+0x34 -> out_valid=0 and sum=0 immediately (asynchronous), in_ready=1. A following 0x12+0x34 yields 0x46 with no residue.
- Builds WIDTH=32 with CHUNK=1, 8 and 32: 1000 random ops each, including sub, compared against reference arithmetic (sum, c_out, overflow) -> zero mismatches. Latency is exactly 32, 4 and 1 cycles respectively.
- With SERIAL_ADDER_SUB_ZERO_FLAG_EN: 0x05 - 0x05 -> zero=1, c_out=1; 0x05 + 0x00 -> zero=0. Without the macro, the design elaborates with no zero port.

Source files
------------

// File: rtl/serial_adder_sub.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock, valid/ready on both sides.
// Optional `SERIAL_ADDER_SUB_ZERO_FLAG_EN adds a registered zero-result flag output.
module serial_adder_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK:0]   c_chain;
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
  logic             zacc_q, zacc_d, zero_q, zero_d;
`endif

  always_comb begin
    c_chain    = '0;
    s_chunk    = '0;
    c_chain[0] = carry_q;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s_chunk[i]   = a_q[i] ^ b_q[i] ^ c_chain[i];
      c_chain[i+1] = (a_q[i] & b_q[i]) | (c_chain[i] & (a_q[i] ^ b_q[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
    zacc_d  = zacc_q;
    zero_d  = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = operand_a;
          b_d     = operand_b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
          zacc_d  = 1'b1;
`endif
          state_d = ADD;
        end
      end
      ADD: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        // Result enters from the top so the LSB chunk ends at bit 0 after NCHUNK shifts.
        sum_d = sum_q >> CHUNK;
        sum_d[WIDTH-1 -: CHUNK] = s_chunk;
        carry_d = c_chain[CHUNK];
        cnt_d   = cnt_q + CW'(1);
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
        zacc_d  = zacc_q & ~(|s_chunk);
`endif
        if (cnt_q == CW'(NCHUNK - 1)) begin
          c_out_d = c_chain[CHUNK];
          ovf_d   = c_chain[CHUNK] ^ c_chain[CHUNK-1];
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
          zero_d  = zacc_q & ~(|s_chunk);
`endif
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
      zacc_q  <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
      zacc_q  <= zacc_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench: three WIDTH=8 builds (CHUNK=4, 1, 8) driven in lockstep, checked against an arithmetic model.
module tb_serial_adder_sub;

  localparam int NI = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] operand_a, operand_b;
  logic       sub;

  logic       d_ir[NI], d_ov[NI], d_c[NI], d_v[NI], d_z[NI];
  logic [7:0] d_sum[NI];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CK = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    serial_adder_sub #(.WIDTH(8), .CHUNK(CK)) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (d_ir[g]),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .sub       (sub),
      .out_valid (d_ov[g]),
      .out_ready (out_ready),
      .sum       (d_sum[g]),
      .c_out     (d_c[g]),
      .overflow  (d_v[g])
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
      ,
      .zero      (d_z[g])
`endif
    );
`ifndef SERIAL_ADDER_SUB_ZERO_FLAG_EN
    assign d_z[g] = 1'b0;
`endif
  end

  always #5 clock = ~clock;

  function automatic int nch(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 8 : 1);
  endfunction

  // Reference result packed as {zero, overflow, c_out, sum}.
  function automatic logic [10:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    int sa, sb, r;
    logic [7:0] res;
    logic c, v;
    sa  = (a > 8'd127) ? int'(a) - 256 : int'(a);
    sb  = (b > 8'd127) ? int'(b) - 256 : int'(b);
    r   = s ? sa - sb : sa + sb;
    v   = (r > 127) || (r < -128);
    res = r[7:0];
    c   = s ? (a >= b) : ((int'(a) + int'(b)) > 255);
    return {(res == 8'd0), v, c, res};
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Model: 0 = idle, 1 = busy, 2 = done
  int          m_st[NI];
  int          m_cnt[NI];
  logic [10:0] m_pend[NI];
  logic [10:0] m_exp[NI];

  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) begin
        m_st[i]  <= 0;
        m_cnt[i] <= 0;
        m_exp[i] <= '0;
      end else begin
        case (m_st[i])
          0: if (in_valid) begin
               m_st[i]   <= 1;
               m_cnt[i]  <= nch(i);
               m_pend[i] <= ref_op(operand_a, operand_b, sub);
             end
          1: if (m_cnt[i] == 1) begin
               m_st[i]  <= 2;
               m_exp[i] <= m_pend[i];
             end else begin
               m_cnt[i] <= m_cnt[i] - 1;
             end
          default: if (out_ready) m_st[i] <= 0;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      check("in_ready", i, 32'(d_ir[i]), 32'(m_st[i] == 0));
      check("out_valid", i, 32'(d_ov[i]), 32'(m_st[i] == 2));
      if (m_st[i] != 1) begin
        check("sum", i, 32'(d_sum[i]), 32'(m_exp[i][7:0]));
        check("c_out", i, 32'(d_c[i]), 32'(m_exp[i][8]));
        check("overflow", i, 32'(d_v[i]), 32'(m_exp[i][9]));
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
        check("zero", i, 32'(d_z[i]), 32'(m_exp[i][10]));
`endif
      end
    end
  end

  function automatic logic all_idle();
    return (m_st[0] == 0) && (m_st[1] == 0) && (m_st[2] == 0);
  endfunction

  task automatic wait_all_idle();
    int t = 0;
    while (!all_idle() && t < 64) begin
      @(posedge clock); #1;
      t++;
    end
    check("idle_timeout", 0, 32'(t < 64), 32'd1);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
    wait_all_idle();
    operand_a = a;
    operand_b = b;
    sub       = s;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    in_valid  = 1'b0;
  endtask

  task automatic vec(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [7:0] es, input logic ec, input logic ev, input logic ez);
    issue(a, b, s);
    wait_all_idle();
    for (int i = 0; i < NI; i++) begin
      check("lit_sum", i, 32'(d_sum[i]), 32'(es));
      check("lit_c_out", i, 32'(d_c[i]), 32'(ec));
      check("lit_overflow", i, 32'(d_v[i]), 32'(ev));
`ifdef SERIAL_ADDER_SUB_ZERO_FLAG_EN
      check("lit_zero", i, 32'(d_z[i]), 32'(ez));
`endif
    end
    check("model_pin", 0, 32'(m_exp[0]), 32'({ez, ev, ec, es}));
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operand_a = '0;
    operand_b = '0;
    sub       = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_in_ready", i, 32'(d_ir[i]), 32'd1);
      check("rst_out_valid", i, 32'(d_ov[i]), 32'd0);
      check("rst_sum", i, 32'(d_sum[i]), 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    vec(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    vec(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    vec(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    vec(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
    vec(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    vec(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    vec(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    vec(8'h05, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);

    // Backpressure with ignored in_valid pulses while busy/done
    out_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0);
    for (int k = 0; k < 14; k++) begin
      operand_a = 8'hAA;
      operand_b = 8'h55;
      sub       = k[0];
      in_valid  = k[0];
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      check("bp_out_valid", i, 32'(d_ov[i]), 32'd1);
      check("bp_in_ready", i, 32'(d_ir[i]), 32'd0);
      check("bp_sum", i, 32'(d_sum[i]), 32'h46);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      check("drain_in_ready", i, 32'(d_ir[i]), 32'd1);
      check("drain_out_valid", i, 32'(d_ov[i]), 32'd0);
      check("drain_sum_hold", i, 32'(d_sum[i]), 32'h46);
    end
    out_ready = 1'b1;

    // Asynchronous reset one cycle after accept
    vec(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    issue(8'h12, 8'h34, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("arst_out_valid", i, 32'(d_ov[i]), 32'd0);
      check("arst_sum", i, 32'(d_sum[i]), 32'd0);
      check("arst_in_ready", i, 32'(d_ir[i]), 32'd1);
      check("arst_flags", i, 32'({d_c[i], d_v[i]}), 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    vec(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    // Random operations checked by the model every cycle
    for (int k = 0; k < 40; k++) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    wait_all_idle();
    repeat (2) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
